// File: rtl/mbp_update_gen_pkg.sv
// Shared configuration and predictor-facing types for the branch update generator.
// The core config is derived from a user-level description by build_config.
package mbp_update_gen_pkg;

    typedef struct packed {
        int unsigned VLEN;
        int unsigned GbpEntries;
        int unsigned LbpEntries;
    } cva6_user_cfg_t;

    typedef struct packed {
        int unsigned VLEN;
        int unsigned GIdxBits;
        int unsigned LIdxBits;
    } cva6_cfg_t;

    localparam cva6_user_cfg_t cva6_cfg = '{VLEN: 32, GbpEntries: 256, LbpEntries: 256};

    function automatic cva6_cfg_t build_config(input cva6_user_cfg_t userCfg);
        cva6_cfg_t cfg;
        cfg.VLEN     = userCfg.VLEN;
        cfg.GIdxBits = $clog2(userCfg.GbpEntries);
        cfg.LIdxBits = $clog2(userCfg.LbpEntries);
        return cfg;
    endfunction

    localparam cva6_cfg_t   DefaultCfg = build_config(cva6_cfg);
    localparam int unsigned MbpVlen    = DefaultCfg.VLEN;
    localparam int unsigned GIdxW      = DefaultCfg.GIdxBits;
    localparam int unsigned LIdxW      = DefaultCfg.LIdxBits;

    typedef struct packed {
        logic [GIdxW-1:0] gindex;
        logic             gbp_valid;
        logic             gbp_taken;
        logic [LIdxW-1:0] lindex;
        logic             lbp_valid;
        logic             lbp_taken;
    } bp_metadata_t;

    typedef struct packed {
        logic               valid;
        logic [MbpVlen-1:0] pc;
        logic               taken;
        bp_metadata_t       metadata;
    } bht_update_t;

endpackage

// File: rtl/mbp_update_gen_store.sv
// Entry storage for in-flight branches: one write port, one asynchronous read port.
// Contents are intentionally not reset; validity is tracked by the owner's occupancy count.
module mbp_update_gen_store
    import mbp_update_gen_pkg::*;
#(
    parameter int unsigned DEPTH = 8,
    parameter type         entry_t = logic,
    localparam int unsigned PtrW = $clog2(DEPTH)
) (
    input  logic            clk_i,
    input  logic            we_i,
    input  logic [PtrW-1:0] waddr_i,
    input  entry_t          wdata_i,
    input  logic [PtrW-1:0] raddr_i,
    output entry_t          rdata_o
);

    entry_t mem_q [DEPTH];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/mbp_update_gen.sv
// Queues branch predictions in issue order and, as branches resolve in order,
// emits one-cycle-delayed predictor updates plus misprediction pulses and count.
module mbp_update_gen
    import mbp_update_gen_pkg::*;
#(
    parameter cva6_cfg_t   CVA6Cfg       = mbp_update_gen_pkg::build_config(mbp_update_gen_pkg::cva6_cfg),
    parameter type         bht_update_t  = mbp_update_gen_pkg::bht_update_t,
    parameter type         bp_metadata_t = mbp_update_gen_pkg::bp_metadata_t,
    parameter int unsigned DEPTH         = 8
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    flush_i,
    input  logic                    debug_mode_i,
    input  logic                    push_valid_i,
    input  logic [CVA6Cfg.VLEN-1:0] push_pc_i,
    input  logic                    push_taken_i,
    input  bp_metadata_t            push_meta_i,
    output logic                    push_ready_o,
    input  logic                    resolve_valid_i,
    input  logic                    resolve_taken_i,
    output bht_update_t             bht_update_o,
    output logic                    mispredict_o,
    output logic                    resolve_err_o,
    output logic [31:0]             mispredict_cnt_o
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = PtrW + 1;

    typedef struct packed {
        logic [CVA6Cfg.VLEN-1:0] pc;
        logic                    taken;
        bp_metadata_t            meta;
    } entry_t;

    logic [PtrW-1:0] wrPtr_q, wrPtr_d;
    logic [PtrW-1:0] rdPtr_q, rdPtr_d;
    logic [CntW-1:0] count_q, count_d;
    bht_update_t     update_q, update_d;
    logic            mispredict_q, mispredict_d;
    logic            resolveErr_q, resolveErr_d;
    logic [31:0]     misCnt_q, misCnt_d;

    logic   full, empty, pushEn, popEn;
    entry_t wrEntry, rdEntry;

    // Readiness comes from registered occupancy only, so a full queue never
    // accepts a push even when a pop happens in the same cycle.
    assign full         = (count_q == CntW'(DEPTH));
    assign empty        = (count_q == '0);
    assign push_ready_o = !full;
    assign pushEn       = push_valid_i && !full && !flush_i;
    assign popEn        = resolve_valid_i && !empty && !flush_i;

    assign wrEntry.pc    = push_pc_i;
    assign wrEntry.taken = push_taken_i;
    assign wrEntry.meta  = push_meta_i;

    mbp_update_gen_store #(
        .DEPTH   (DEPTH),
        .entry_t (entry_t)
    ) i_store (
        .clk_i   (clk_i),
        .we_i    (pushEn),
        .waddr_i (wrPtr_q),
        .wdata_i (wrEntry),
        .raddr_i (rdPtr_q),
        .rdata_o (rdEntry)
    );

    always_comb begin
        wrPtr_d = wrPtr_q;
        rdPtr_d = rdPtr_q;
        count_d = count_q;
        if (flush_i) begin
            wrPtr_d = '0;
            rdPtr_d = '0;
            count_d = '0;
        end else begin
            if (pushEn) begin
                wrPtr_d = wrPtr_q + PtrW'(1);
            end
            if (popEn) begin
                rdPtr_d = rdPtr_q + PtrW'(1);
            end
            unique case ({pushEn, popEn})
                2'b10:   count_d = count_q + CntW'(1);
                2'b01:   count_d = count_q - CntW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Debug mode still consumes the entry but hides it from the predictor.
    always_comb begin
        update_d          = '0;
        update_d.valid    = popEn && !debug_mode_i;
        update_d.pc       = rdEntry.pc;
        update_d.taken    = resolve_taken_i;
        update_d.metadata = rdEntry.meta;
        mispredict_d      = popEn && !debug_mode_i && (resolve_taken_i != rdEntry.taken);
        resolveErr_d      = resolve_valid_i && empty && !flush_i;
        misCnt_d          = misCnt_q;
        if (mispredict_d && (misCnt_q != 32'hFFFF_FFFF)) begin
            misCnt_d = misCnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wrPtr_q      <= '0;
            rdPtr_q      <= '0;
            count_q      <= '0;
            update_q     <= '0;
            mispredict_q <= 1'b0;
            resolveErr_q <= 1'b0;
            misCnt_q     <= '0;
        end else begin
            wrPtr_q      <= wrPtr_d;
            rdPtr_q      <= rdPtr_d;
            count_q      <= count_d;
            update_q     <= update_d;
            mispredict_q <= mispredict_d;
            resolveErr_q <= resolveErr_d;
            misCnt_q     <= misCnt_d;
        end
    end

    assign bht_update_o     = update_q;
    assign mispredict_o     = mispredict_q;
    assign resolve_err_o    = resolveErr_q;
    assign mispredict_cnt_o = misCnt_q;

endmodule

// File: tb/tb_mbp_update_gen.sv
// Directed and randomized checks of the branch update generator against
// hand-computed values and a shadow queue model.
module tb_mbp_update_gen;
    import mbp_update_gen_pkg::*;

    localparam int unsigned DEPTH = 8;

    typedef struct {
        logic [MbpVlen-1:0] pc;
        logic               taken;
        bp_metadata_t       meta;
    } model_entry_t;

    logic               clk = 1'b0;
    logic               rstN;
    logic               flush;
    logic               debugMode;
    logic               pushValid;
    logic [MbpVlen-1:0] pushPc;
    logic               pushTaken;
    bp_metadata_t       pushMeta;
    logic               pushReady;
    logic               resolveValid;
    logic               resolveTaken;
    bht_update_t        bhtUpdate;
    logic               mispredict;
    logic               resolveErr;
    logic [31:0]        misCnt;

    int          testsRun  = 0;
    int          failCount = 0;
    int unsigned expCnt    = 0;

    always #5 clk = ~clk;

    mbp_update_gen #(
        .CVA6Cfg       (build_config(cva6_cfg)),
        .bht_update_t  (bht_update_t),
        .bp_metadata_t (bp_metadata_t),
        .DEPTH         (DEPTH)
    ) dut (
        .clk_i            (clk),
        .rst_ni           (rstN),
        .flush_i          (flush),
        .debug_mode_i     (debugMode),
        .push_valid_i     (pushValid),
        .push_pc_i        (pushPc),
        .push_taken_i     (pushTaken),
        .push_meta_i      (pushMeta),
        .push_ready_o     (pushReady),
        .resolve_valid_i  (resolveValid),
        .resolve_taken_i  (resolveTaken),
        .bht_update_o     (bhtUpdate),
        .mispredict_o     (mispredict),
        .resolve_err_o    (resolveErr),
        .mispredict_cnt_o (misCnt)
    );

    function automatic bp_metadata_t mkMeta(input logic [GIdxW-1:0] g, input logic [LIdxW-1:0] l);
        bp_metadata_t m;
        m           = '0;
        m.gindex    = g;
        m.gbp_valid = 1'b1;
        m.gbp_taken = g[0];
        m.lindex    = l;
        m.lbp_valid = 1'b1;
        m.lbp_taken = l[0];
        return m;
    endfunction

    // Drive one cycle of inputs, let the edge consume them, then sample 1 ns later.
    task automatic applyStimulus(input logic pv, input logic [MbpVlen-1:0] pc, input logic pt,
                                 input bp_metadata_t meta, input logic rv, input logic rt,
                                 input logic fl, input logic dbg);
        pushValid    = pv;
        pushPc       = pc;
        pushTaken    = pt;
        pushMeta     = meta;
        resolveValid = rv;
        resolveTaken = rt;
        flush        = fl;
        debugMode    = dbg;
        @(posedge clk);
        #1;
        pushValid    = 1'b0;
        resolveValid = 1'b0;
        flush        = 1'b0;
        debugMode    = 1'b0;
    endtask

    task automatic doPush(input logic [MbpVlen-1:0] pc, input logic pt, input bp_metadata_t meta);
        applyStimulus(1'b1, pc, pt, meta, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic doResolve(input logic rt);
        applyStimulus(1'b0, '0, 1'b0, '0, 1'b1, rt, 1'b0, 1'b0);
    endtask

    task automatic doIdle();
        applyStimulus(1'b0, '0, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_reset();
        rstN = 1'b1;
        #1;
        rstN = 1'b0;
        #1;
        testsRun++;
        if (pushReady !== 1'b1) begin failCount++; $display("[TB] FAIL reset_ready: got %b expected 1", pushReady); end
        testsRun++;
        if (bhtUpdate.valid !== 1'b0) begin failCount++; $display("[TB] FAIL reset_valid: got %b expected 0", bhtUpdate.valid); end
        testsRun++;
        if (mispredict !== 1'b0 || resolveErr !== 1'b0) begin
            failCount++; $display("[TB] FAIL reset_pulses: got mis=%b err=%b expected 0 0", mispredict, resolveErr);
        end
        testsRun++;
        if (misCnt !== 32'd0) begin failCount++; $display("[TB] FAIL reset_cnt: got %0d expected 0", misCnt); end
        @(posedge clk);
        #4;
        rstN   = 1'b1;
        expCnt = 0;
        doIdle();
    endtask

    task automatic test_mispredict();
        doPush(32'h8000_0000, 1'b1, mkMeta(GIdxW'(5), LIdxW'(9)));
        doResolve(1'b0);
        expCnt++;
        testsRun++;
        if (bhtUpdate.valid !== 1'b1 || bhtUpdate.pc !== 32'h8000_0000 || bhtUpdate.taken !== 1'b0) begin
            failCount++;
            $display("[TB] FAIL mis_update: got v=%b pc=%h t=%b expected 1 80000000 0", bhtUpdate.valid, bhtUpdate.pc, bhtUpdate.taken);
        end
        testsRun++;
        if (bhtUpdate.metadata !== mkMeta(GIdxW'(5), LIdxW'(9))) begin
            failCount++; $display("[TB] FAIL mis_meta: got gindex=%0d expected 5", bhtUpdate.metadata.gindex);
        end
        testsRun++;
        if (mispredict !== 1'b1 || misCnt !== expCnt) begin
            failCount++; $display("[TB] FAIL mis_pulse: got mis=%b cnt=%0d expected 1 %0d", mispredict, misCnt, expCnt);
        end
        doIdle();
        testsRun++;
        if (bhtUpdate.valid !== 1'b0 || mispredict !== 1'b0 || misCnt !== expCnt) begin
            failCount++;
            $display("[TB] FAIL mis_one_cycle: got v=%b mis=%b cnt=%0d expected 0 0 %0d", bhtUpdate.valid, mispredict, misCnt, expCnt);
        end
    endtask

    task automatic test_fill_drain();
        for (int i = 0; i < DEPTH; i++) begin
            doPush(32'h1000 + 32'(i * 4), i[0], mkMeta(GIdxW'(i), LIdxW'(i + 1)));
        end
        testsRun++;
        if (pushReady !== 1'b0) begin failCount++; $display("[TB] FAIL full_ready: got %b expected 0", pushReady); end
        doPush(32'hDEAD_0000, 1'b1, mkMeta('1, '1));
        for (int i = 0; i < DEPTH; i++) begin
            doResolve(i[0]);
            testsRun++;
            if (bhtUpdate.valid !== 1'b1 || bhtUpdate.pc !== 32'h1000 + 32'(i * 4) || mispredict !== 1'b0
                || bhtUpdate.metadata !== mkMeta(GIdxW'(i), LIdxW'(i + 1))) begin
                failCount++;
                $display("[TB] FAIL drain_%0d: got v=%b pc=%h mis=%b expected 1 %h 0", i, bhtUpdate.valid, bhtUpdate.pc,
                         mispredict, 32'h1000 + 32'(i * 4));
            end
        end
        testsRun++;
        if (pushReady !== 1'b1) begin failCount++; $display("[TB] FAIL drained_ready: got %b expected 1", pushReady); end
        doResolve(1'b0);
        testsRun++;
        if (resolveErr !== 1'b1 || bhtUpdate.valid !== 1'b0) begin
            failCount++; $display("[TB] FAIL drained_empty: got err=%b v=%b expected 1 0", resolveErr, bhtUpdate.valid);
        end
    endtask

    task automatic test_full_push_pop();
        for (int i = 0; i < DEPTH; i++) begin
            doPush(32'h2000 + 32'(i * 4), 1'b1, mkMeta(GIdxW'(i), '0));
        end
        applyStimulus(1'b1, 32'hBEEF_0000, 1'b1, '0, 1'b1, 1'b1, 1'b0, 1'b0);
        testsRun++;
        if (bhtUpdate.valid !== 1'b1 || bhtUpdate.pc !== 32'h2000 || pushReady !== 1'b1) begin
            failCount++;
            $display("[TB] FAIL fullpp_pop: got v=%b pc=%h ready=%b expected 1 2000 1", bhtUpdate.valid, bhtUpdate.pc, pushReady);
        end
        for (int i = 1; i < DEPTH; i++) begin
            doResolve(1'b1);
            testsRun++;
            if (bhtUpdate.valid !== 1'b1 || bhtUpdate.pc !== 32'h2000 + 32'(i * 4)) begin
                failCount++;
                $display("[TB] FAIL fullpp_drain_%0d: got v=%b pc=%h expected 1 %h", i, bhtUpdate.valid, bhtUpdate.pc, 32'h2000 + 32'(i * 4));
            end
        end
        doResolve(1'b1);
        testsRun++;
        if (resolveErr !== 1'b1 || bhtUpdate.valid !== 1'b0) begin
            failCount++; $display("[TB] FAIL fullpp_dropped: got err=%b v=%b expected 1 0", resolveErr, bhtUpdate.valid);
        end
    endtask

    task automatic test_empty_resolve();
        doResolve(1'b1);
        testsRun++;
        if (resolveErr !== 1'b1 || bhtUpdate.valid !== 1'b0 || mispredict !== 1'b0) begin
            failCount++;
            $display("[TB] FAIL empty_err: got err=%b v=%b mis=%b expected 1 0 0", resolveErr, bhtUpdate.valid, mispredict);
        end
        doIdle();
        testsRun++;
        if (resolveErr !== 1'b0 || pushReady !== 1'b1) begin
            failCount++; $display("[TB] FAIL empty_once: got err=%b ready=%b expected 0 1", resolveErr, pushReady);
        end
        doPush(32'h4444_0000, 1'b0, mkMeta(GIdxW'(3), LIdxW'(4)));
        doResolve(1'b0);
        testsRun++;
        if (bhtUpdate.valid !== 1'b1 || bhtUpdate.pc !== 32'h4444_0000 || resolveErr !== 1'b0) begin
            failCount++;
            $display("[TB] FAIL empty_after: got v=%b pc=%h err=%b expected 1 44440000 0", bhtUpdate.valid, bhtUpdate.pc, resolveErr);
        end
    endtask

    task automatic test_flush();
        for (int i = 0; i < 3; i++) begin
            doPush(32'h5000 + 32'(i * 4), 1'b1, '0);
        end
        applyStimulus(1'b0, '0, 1'b0, '0, 1'b1, 1'b0, 1'b1, 1'b0);
        testsRun++;
        if (bhtUpdate.valid !== 1'b0 || mispredict !== 1'b0 || resolveErr !== 1'b0 || pushReady !== 1'b1) begin
            failCount++;
            $display("[TB] FAIL flush_override: got v=%b mis=%b err=%b ready=%b expected 0 0 0 1", bhtUpdate.valid,
                     mispredict, resolveErr, pushReady);
        end
        doResolve(1'b1);
        testsRun++;
        if (resolveErr !== 1'b1 || bhtUpdate.valid !== 1'b0) begin
            failCount++; $display("[TB] FAIL flush_empty: got err=%b v=%b expected 1 0", resolveErr, bhtUpdate.valid);
        end
    endtask

    task automatic test_debug();
        doPush(32'h6000_0000, 1'b1, '0);
        applyStimulus(1'b0, '0, 1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b1);
        testsRun++;
        if (bhtUpdate.valid !== 1'b0 || mispredict !== 1'b0 || misCnt !== expCnt) begin
            failCount++;
            $display("[TB] FAIL debug_suppress: got v=%b mis=%b cnt=%0d expected 0 0 %0d", bhtUpdate.valid, mispredict, misCnt, expCnt);
        end
        doResolve(1'b0);
        testsRun++;
        if (resolveErr !== 1'b1 || bhtUpdate.valid !== 1'b0) begin
            failCount++; $display("[TB] FAIL debug_popped: got err=%b v=%b expected 1 0", resolveErr, bhtUpdate.valid);
        end
    endtask

    task automatic test_back_to_back();
        doPush(32'h3000, 1'b1, mkMeta(GIdxW'(1), '0));
        applyStimulus(1'b1, 32'h3004, 1'b0, mkMeta(GIdxW'(2), '0), 1'b1, 1'b0, 1'b0, 1'b0);
        expCnt++;
        testsRun++;
        if (bhtUpdate.valid !== 1'b1 || bhtUpdate.pc !== 32'h3000 || mispredict !== 1'b1 || misCnt !== expCnt) begin
            failCount++;
            $display("[TB] FAIL b2b_a: got v=%b pc=%h mis=%b cnt=%0d expected 1 3000 1 %0d", bhtUpdate.valid, bhtUpdate.pc,
                     mispredict, misCnt, expCnt);
        end
        applyStimulus(1'b1, 32'h3008, 1'b1, mkMeta(GIdxW'(3), '0), 1'b1, 1'b0, 1'b0, 1'b0);
        testsRun++;
        if (bhtUpdate.valid !== 1'b1 || bhtUpdate.pc !== 32'h3004 || mispredict !== 1'b0 || misCnt !== expCnt) begin
            failCount++;
            $display("[TB] FAIL b2b_b: got v=%b pc=%h mis=%b cnt=%0d expected 1 3004 0 %0d", bhtUpdate.valid, bhtUpdate.pc,
                     mispredict, misCnt, expCnt);
        end
        doResolve(1'b0);
        expCnt++;
        testsRun++;
        if (bhtUpdate.valid !== 1'b1 || bhtUpdate.pc !== 32'h3008 || mispredict !== 1'b1 || misCnt !== expCnt) begin
            failCount++;
            $display("[TB] FAIL b2b_c: got v=%b pc=%h mis=%b cnt=%0d expected 1 3008 1 %0d", bhtUpdate.valid, bhtUpdate.pc,
                     mispredict, misCnt, expCnt);
        end
        doResolve(1'b0);
        testsRun++;
        if (resolveErr !== 1'b1) begin failCount++; $display("[TB] FAIL b2b_empty: got err=%b expected 1", resolveErr); end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 3; i++) begin
            doPush(32'h7000 + 32'(i * 4), 1'b0, '0);
        end
        #2;
        rstN = 1'b0;
        #1;
        testsRun++;
        if (pushReady !== 1'b1 || misCnt !== 32'd0 || bhtUpdate.valid !== 1'b0) begin
            failCount++;
            $display("[TB] FAIL async_reset: got ready=%b cnt=%0d v=%b expected 1 0 0", pushReady, misCnt, bhtUpdate.valid);
        end
        #1;
        rstN   = 1'b1;
        expCnt = 0;
        doResolve(1'b1);
        testsRun++;
        if (resolveErr !== 1'b1 || bhtUpdate.valid !== 1'b0) begin
            failCount++; $display("[TB] FAIL async_reset_empty: got err=%b v=%b expected 1 0", resolveErr, bhtUpdate.valid);
        end
    endtask

    task automatic test_random();
        model_entry_t q[$];
        model_entry_t e;
        int           dbgLeft = 0;
        logic         dbgOn   = 1'b0;
        for (int cyc = 0; cyc < 10000; cyc++) begin
            logic               pv, pt, rv, rt, fl;
            logic [MbpVlen-1:0] pc;
            bp_metadata_t       meta;
            logic               expValid, expMis, expErr;
            model_entry_t       expE;
            int                 sizeBefore;
            if (dbgLeft == 0) begin
                dbgOn   = ($urandom_range(0, 99) < 20);
                dbgLeft = $urandom_range(20, 60);
            end
            dbgLeft--;
            pv   = ($urandom_range(0, 99) < 55);
            rv   = ($urandom_range(0, 99) < 50);
            fl   = ($urandom_range(0, 99) < 2);
            pt   = $urandom_range(0, 1) == 1;
            rt   = $urandom_range(0, 1) == 1;
            pc   = MbpVlen'($urandom) & ~MbpVlen'(3);
            meta = mkMeta(GIdxW'($urandom), LIdxW'($urandom));
            sizeBefore = q.size();
            testsRun++;
            if (pushReady !== (sizeBefore != DEPTH)) begin
                failCount++; $display("[TB] FAIL rand_ready@%0d: got %b expected %b", cyc, pushReady, sizeBefore != DEPTH);
            end
            expValid = 1'b0;
            expMis   = 1'b0;
            expErr   = 1'b0;
            expE     = '{pc: '0, taken: 1'b0, meta: '0};
            if (fl) begin
                q.delete();
            end else begin
                if (rv && sizeBefore > 0) begin
                    e    = q.pop_front();
                    expE = e;
                    if (!dbgOn) begin
                        expValid = 1'b1;
                        if (rt != e.taken) begin
                            expMis = 1'b1;
                            if (expCnt != 32'hFFFF_FFFF) expCnt++;
                        end
                    end
                end else if (rv) begin
                    expErr = 1'b1;
                end
                if (pv && sizeBefore < DEPTH) begin
                    q.push_back('{pc: pc, taken: pt, meta: meta});
                end
            end
            applyStimulus(pv, pc, pt, meta, rv, rt, fl, dbgOn);
            testsRun++;
            if (bhtUpdate.valid !== expValid) begin
                failCount++; $display("[TB] FAIL rand_valid@%0d: got %b expected %b", cyc, bhtUpdate.valid, expValid);
            end else if (expValid) begin
                testsRun++;
                if (bhtUpdate.pc !== expE.pc || bhtUpdate.taken !== rt || bhtUpdate.metadata !== expE.meta) begin
                    failCount++;
                    $display("[TB] FAIL rand_fields@%0d: got pc=%h t=%b meta=%h expected %h %b %h", cyc, bhtUpdate.pc,
                             bhtUpdate.taken, bhtUpdate.metadata, expE.pc, rt, expE.meta);
                end
            end
            testsRun++;
            if (mispredict !== expMis || resolveErr !== expErr || misCnt !== expCnt) begin
                failCount++;
                $display("[TB] FAIL rand_flags@%0d: got mis=%b err=%b cnt=%0d expected %b %b %0d", cyc, mispredict,
                         resolveErr, misCnt, expMis, expErr, expCnt);
            end
        end
    endtask

    initial begin
        flush        = 1'b0;
        debugMode    = 1'b0;
        pushValid    = 1'b0;
        pushPc       = '0;
        pushTaken    = 1'b0;
        pushMeta     = '0;
        resolveValid = 1'b0;
        resolveTaken = 1'b0;
        test_reset();
        test_mispredict();
        test_fill_drain();
        test_full_push_pop();
        test_empty_resolve();
        test_flush();
        test_debug();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
        $finish;
    end

endmodule

// File: doc/mbp_update_gen.md
MBP_UPDATE_GEN -- requirements
Module: mbp_update_gen

Interface
REQ-001 SHALL have parameter CVA6Cfg, default build_config(cva6_cfg), core configuration (VLEN, predictor index widths).
REQ-002 SHALL have parameter bht_update_t, default none, predictor update struct {valid, pc, taken, metadata}.
REQ-003 SHALL have parameter bp_metadata_t, default none, predictor metadata struct {gindex, gbp_valid, gbp_taken, lindex, lbp_valid, lbp_taken}.
REQ-004 SHALL have parameter DEPTH, default 8, in-flight branch entries; power of two, at least 2.
REQ-005 clk_i  in  1  single clock; all state on rising edge.
REQ-006 rst_ni  in  1  reset, asynchronous, active-low.
REQ-007 flush_i  in  1  discard all in-flight entries.
REQ-008 debug_mode_i  in  1  suppress predictor updates while high.
REQ-009 push_valid_i  in  1  a prediction has been issued for a branch.
REQ-010 push_pc_i  in  VLEN  branch PC.
REQ-011 push_taken_i  in  1  predicted direction.
REQ-012 push_meta_i  in  bp_metadata_t  metadata returned with the prediction.
REQ-013 push_ready_o  out  1  entry available.
REQ-014 resolve_valid_i  in  1  oldest branch resolved; in-order only.
REQ-015 resolve_taken_i  in  1  actual direction.
REQ-016 bht_update_o  out  bht_update_t  update to the predictor.
REQ-017 mispredict_o  out  1  one-cycle pulse: resolved direction differs from the prediction.
REQ-018 resolve_err_o  out  1  one-cycle pulse: resolve arrived with the queue empty.
REQ-019 mispredict_cnt_o  out  32  saturating misprediction count.

Function
REQ-020 Entries SHALL be held in a circular FIFO: write pointer, read pointer, occupancy counter 0..DEPTH.
REQ-021 push_ready_o SHALL equal (count != DEPTH), from registered state only, with no dependence on resolve_valid_i.
REQ-022 A push SHALL be accepted when push_valid_i and push_ready_o are both high; push_valid_i while full SHALL be dropped with no state change.
REQ-023 A resolve with count > 0 SHALL pop the oldest entry. On the next cycle bht_update_o SHALL carry valid=1, the entry pc, taken=resolve_taken_i and the entry metadata unchanged.
REQ-024 Update latency SHALL be exactly one cycle; bht_update_o.valid SHALL be high for one cycle per pop.
REQ-025 mispredict_o SHALL be asserted in the same cycle as the corresponding bht_update_o.valid, when resolve_taken_i != the stored predicted direction.
REQ-026 mispredict_cnt_o SHALL increment on each mispredict_o pulse and saturate at 0xFFFFFFFF.
REQ-027 A resolve with count == 0 SHALL pulse resolve_err_o the next cycle, produce no update, and leave the pointers unchanged.
REQ-028 A push and a pop in the same cycle SHALL both take effect and leave count unchanged. When full, only the pop SHALL take effect (REQ-021).
REQ-029 Pointers SHALL wrap modulo DEPTH.
REQ-030 flush_i SHALL zero the pointers and count on the next edge and override any same-cycle push or resolve. An update already registered before flush_i SHALL still be presented.
REQ-031 While debug_mode_i is high, a pop SHALL still occur, but bht_update_o.valid, mispredict_o and the counter increment SHALL be suppressed.
REQ-032 When bht_update_o.valid is 0, the other bht_update_o fields are don't-care.

Reset
REQ-033 While rst_ni is low: pointers and count SHALL be 0; bht_update_o.valid, mispredict_o and resolve_err_o SHALL be 0; mispredict_cnt_o SHALL be 0; push_ready_o SHALL be 1.
REQ-034 Reset asserted mid-operation SHALL discard all entries immediately, asynchronously.
REQ-035 Entry storage need not be reset.

Structure
REQ-036 The bht_update_t and bp_metadata_t typedefs SHALL be defined once in the shared testbench/package layer and passed in as type parameters.
REQ-037 DEPTH SHALL be a module parameter; the pointer width SHALL be $clog2(DEPTH).
REQ-038 Storage SHALL be one sub-module, the existing fifo_v3, or inline registers when occupancy/pointer visibility is required.

Verification
REQ-039 Push pc=0x80000000, taken=1, gindex=5; resolve taken=0 -> next cycle: update valid, pc 0x80000000, taken 0, gindex 5; mispredict_o=1; cnt=1.
REQ-040 Push 8 entries with DEPTH=8 -> push_ready_o=0 and a 9th push is dropped; 8 resolves return the PCs in order, and the final count is 0.
REQ-041 With the queue full, push and resolve in the same cycle -> the pop occurs, the push is dropped, count=7.
REQ-042 Resolve while empty -> resolve_err_o pulses once, no update, count stays 0.
REQ-043 Push 3 entries, assert flush_i together with a resolve -> no update, count=0, push_ready_o=1.
REQ-044 Run 10000 random cycles against a shadow queue model -> every update and mispredict count matches; debug_mode_i=1 windows produce zero updates.
